// File: rtl/msk_encoder_pkg.sv
// Shared types and sizing helpers for the masked share encoder.
package msk_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of randomness transfers needed to encode one word.
  function automatic int unsigned nchunk(input int unsigned nbits, input int unsigned chunk);
    return nbits / chunk;
  endfunction

  // Chunk counter width; at least one bit even for a single-chunk word.
  function automatic int unsigned cnt_width(input int unsigned nbits, input int unsigned chunk);
    int unsigned n;
    n = nbits / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msk_share_chunk.sv
// Combinational per-chunk Boolean sharing: shares 0..d-2 come straight from
// the random bits, share d-1 absorbs the data bit. Output is bit-interleaved
// (share j of bit k at index d*k+j).
module msk_share_chunk #(
  parameter int unsigned d     = 2,
  parameter int unsigned CHUNK = 32
) (
  input  logic [CHUNK-1:0]       data_chunk_i,
  input  logic [(d-1)*CHUNK-1:0] rnd_i,
  output logic [d*CHUNK-1:0]     shares_c_o
);

  // Build the d shares of every bit in the chunk.
  always_comb begin
    logic acc;
    shares_c_o = '0;
    acc        = 1'b0;
    for (int k = 0; k < CHUNK; k++) begin
      acc = data_chunk_i[k];
      for (int j = 0; j < d - 1; j++) begin
        shares_c_o[d*k+j] = rnd_i[j*CHUNK+k];
        acc               = acc ^ rnd_i[j*CHUNK+k];
      end
      shares_c_o[d*k+d-1] = acc;
    end
  end

endmodule

// File: rtl/msk_share_encoder.sv
// Masked encoder: serially turns an unshared Nbits word into its d-share
// interleaved Boolean sharing, consuming one (d-1)*CHUNK random word per chunk.
// Optional feature: MSK_ENCODER_ZEROIZE_EN clears the data register on DONE
// entry and the sharing register on DONE exit.
module msk_share_encoder
  import msk_encoder_pkg::*;
#(
  parameter int unsigned d     = 2,
  parameter int unsigned Nbits = 128,
  parameter int unsigned CHUNK = 32
) (
  input  logic                   clk,
  input  logic                   pre_syn_rst,
  input  logic                   start,
  input  logic [Nbits-1:0]       data_in,
  input  logic [(d-1)*CHUNK-1:0] rnd_in,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  output logic [d*Nbits-1:0]     sharing_out,
  output logic                   sharing_valid,
  input  logic                   out_ack,
  output logic                   busy
);

  localparam int unsigned NCHUNK = nchunk(Nbits, CHUNK);
  localparam int unsigned CNT_W  = cnt_width(Nbits, CHUNK);
  localparam int unsigned SH_W   = d * CHUNK;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [Nbits-1:0]   data_q, data_d;
  logic [d*Nbits-1:0] sharing_q, sharing_d;
  logic               rnd_ready_q, sharing_valid_q, busy_q;

  logic [CHUNK-1:0]   data_chunk_c;
  logic [SH_W-1:0]    shares_c;
  logic               xfer_c;

  assign xfer_c = rnd_valid & rnd_ready_q;

  // Select the data chunk addressed by the counter.
  always_comb begin
    data_chunk_c = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (cnt_q == CNT_W'(c)) data_chunk_c = data_q[c*CHUNK +: CHUNK];
    end
  end

  msk_share_chunk #(
    .d     (d),
    .CHUNK (CHUNK)
  ) u_chunk (
    .data_chunk_i (data_chunk_c),
    .rnd_i        (rnd_in),
    .shares_c_o   (shares_c)
  );

  // Next-state, counter and datapath register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    sharing_d = sharing_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = data_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer_c) begin
          for (int c = 0; c < NCHUNK; c++) begin
            if (cnt_q == CNT_W'(c)) sharing_d[c*SH_W +: SH_W] = shares_c;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NCHUNK - 1)) begin
            state_d = DONE;
`ifdef MSK_ENCODER_ZEROIZE_EN
            data_d  = '0;
`endif
          end
        end
      end
      DONE: begin
        if (out_ack) begin
          state_d   = IDLE;
`ifdef MSK_ENCODER_ZEROIZE_EN
          sharing_d = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (pre_syn_rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      data_q          <= '0;
      sharing_q       <= '0;
      rnd_ready_q     <= 1'b0;
      sharing_valid_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      data_q          <= data_d;
      sharing_q       <= sharing_d;
      rnd_ready_q     <= (state_d == RUN);
      sharing_valid_q <= (state_d == DONE);
      busy_q          <= (state_d != IDLE);
    end
  end

  assign rnd_ready     = rnd_ready_q;
  assign sharing_valid = sharing_valid_q;
  assign busy          = busy_q;
  assign sharing_out   = sharing_q;

endmodule

// File: tb/tb_msk_share_encoder.sv
// Bench for msk_share_encoder: d=2 and d=3 instances, table of vectors plus
// hand sequences for reset abort and ignored start.
module tb_msk_share_encoder;

  localparam int unsigned NB = 128;
  localparam int unsigned CH = 32;
  localparam int unsigned NC = NB / CH;
  localparam int unsigned W  = 3 * NB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            start, rnd_valid, out_ack, rnd_ready, sharing_valid, busy;
  logic [NB-1:0]   data_in;
  logic [CH-1:0]   rnd_in;
  logic [2*NB-1:0] sharing_out;

  logic            start3, rnd_valid3, out_ack3, rnd_ready3, sharing_valid3, busy3;
  logic [NB-1:0]   data_in3;
  logic [2*CH-1:0] rnd_in3;
  logic [3*NB-1:0] sharing_out3;

  msk_share_encoder #(.d(2), .Nbits(NB), .CHUNK(CH)) dut (
    .clk(clk), .pre_syn_rst(rst), .start(start), .data_in(data_in),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sharing_out(sharing_out), .sharing_valid(sharing_valid),
    .out_ack(out_ack), .busy(busy)
  );

  msk_share_encoder #(.d(3), .Nbits(NB), .CHUNK(CH)) dut3 (
    .clk(clk), .pre_syn_rst(rst), .start(start3), .data_in(data_in3),
    .rnd_in(rnd_in3), .rnd_valid(rnd_valid3), .rnd_ready(rnd_ready3),
    .sharing_out(sharing_out3), .sharing_valid(sharing_valid3),
    .out_ack(out_ack3), .busy(busy3)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NB-1:0] data;
    logic          fixed_rnd;
    logic [31:0]   vmask;   // rnd_valid per RUN cycle, bit n = n-th cycle
    logic          noisy;   // keep start high with other data during RUN/DONE
    int            exp_lat; // cycles from start to sharing_valid
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Reference: bit i of the word uses random word i/CH, lane i%CH.
  function automatic logic [W-1:0] model(input int dd, input logic [NB-1:0] data,
                                         input logic [63:0] rq[NC]);
    logic [W-1:0] r;
    logic         acc;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      acc = data[i];
      for (int j = 0; j < dd - 1; j++) begin
        r[dd*i+j] = rq[i/CH][j*CH+i%CH];
        acc       = acc ^ rq[i/CH][j*CH+i%CH];
      end
      r[dd*i+dd-1] = acc;
    end
    return r;
  endfunction

  function automatic logic [NB-1:0] recombine(input int dd, input logic [W-1:0] s);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < dd; j++) r[i] = r[i] ^ s[dd*i+j];
    return r;
  endfunction

  function automatic logic [NB-1:0] share_plane(input int dd, input int j, input logic [W-1:0] s);
    logic [NB-1:0] r;
    for (int i = 0; i < NB; i++) r[i] = s[dd*i+j];
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [63:0]  rq[NC];
    logic [W-1:0] exp;
    int nt, n, lat;
    for (int c = 0; c < NC; c++) rq[c] = '0;
    data_in = v.data;
    start   = 1'b1;
    @(posedge clk); #1;
    if (v.noisy) data_in = ~v.data;
    else start = 1'b0;
    nt = 0; n = 0; lat = 1;
    while (!sharing_valid && lat < 64) begin
      chk("rnd_ready_run", W'(rnd_ready), W'(1'b1));
      chk("busy_run", W'(busy), W'(1'b1));
      rnd_valid = (n < 32) ? v.vmask[n] : 1'b1;
      rnd_in    = v.fixed_rnd ? 32'hDEADBEEF : CH'($urandom);
      if (rnd_valid && nt < int'(NC)) begin
        rq[nt] = {32'h0, rnd_in};
        nt++;
      end
      @(posedge clk); #1;
      lat++; n++;
    end
    rnd_valid = 1'b0;
    exp = model(2, v.data, rq);
    chk("latency", W'(lat), W'(v.exp_lat));
    chk("sharing", W'(sharing_out), exp);
    chk("recombine", W'(recombine(2, W'(sharing_out))), W'(v.data));
    chk("rnd_ready_done", W'(rnd_ready), W'(1'b0));
    if (v.fixed_rnd)
      chk("share0_deadbeef", W'(share_plane(2, 0, W'(sharing_out))), W'({4{32'hDEADBEEF}}));
    // Hold in DONE one cycle without ack.
    @(posedge clk); #1;
    chk("valid_hold", W'(sharing_valid), W'(1'b1));
    chk("sharing_hold", W'(sharing_out), exp);
`ifdef MSK_ENCODER_ZEROIZE_EN
    chk("data_zeroized", W'(dut.data_q), W'(0));
`endif
    out_ack = 1'b1;
    start   = 1'b0;
    @(posedge clk); #1;
    out_ack = 1'b0;
    chk("busy_after_ack", W'(busy), W'(1'b0));
    chk("valid_after_ack", W'(sharing_valid), W'(1'b0));
    chk("rnd_ready_idle", W'(rnd_ready), W'(1'b0));
`ifdef MSK_ENCODER_ZEROIZE_EN
    chk("sharing_zeroized", W'(sharing_out), W'(0));
`else
    chk("sharing_retained", W'(sharing_out), exp);
`endif
  endtask

  task automatic run_d3(input logic [NB-1:0] data);
    logic [63:0]  rq[NC];
    logic [NB-1:0] up;
    int lat;
    data_in3 = data;
    start3   = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    rnd_valid3 = 1'b1;
    lat = 1;
    for (int c = 0; c < int'(NC); c++) begin
      rnd_in3 = {32'($urandom), 32'($urandom)};
      rq[c]   = rnd_in3;
      @(posedge clk); #1;
      lat++;
    end
    rnd_valid3 = 1'b0;
    for (int i = 0; i < NB; i++) up[i] = rq[i/CH][CH+i%CH];
    chk("d3_valid", W'(sharing_valid3), W'(1'b1));
    chk("d3_latency", W'(lat), W'(5));
    chk("d3_sharing", sharing_out3, model(3, data, rq));
    chk("d3_recombine", W'(recombine(3, sharing_out3)), W'(data));
    chk("d3_share1", W'(share_plane(3, 1, sharing_out3)), W'(up));
    out_ack3 = 1'b1;
    @(posedge clk); #1;
    out_ack3 = 1'b0;
    chk("d3_busy_after_ack", W'(busy3), W'(1'b0));
  endtask

  initial begin
    logic [NB-1:0] d0;
    d0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    vecs[0] = '{d0, 1'b1, 32'hFFFF_FFFF, 1'b0, 5};
    vecs[1] = '{d0, 1'b1, 32'hAAAA_AAAA, 1'b0, 9};
    vecs[2] = '{{32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)},
                1'b0, 32'h5555_5555, 1'b0, 8};
    vecs[3] = '{d0, 1'b0, 32'hFFFF_FFFF, 1'b1, 5};
    vecs[4] = '{~d0, 1'b0, 32'hFFFF_FFF8, 1'b0, 8};

    rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; out_ack = 1'b0;
    data_in = '0; rnd_in = '0;
    start3 = 1'b0; rnd_valid3 = 1'b0; out_ack3 = 1'b0;
    data_in3 = '0; rnd_in3 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", W'(busy), W'(1'b0));
    chk("rst_valid", W'(sharing_valid), W'(1'b0));
    chk("rst_rnd_ready", W'(rnd_ready), W'(1'b0));
    chk("rst_sharing", W'(sharing_out), W'(0));
    chk("rst_sharing_d3", sharing_out3, W'(0));

    // Idle: no start, nothing consumed.
    rnd_valid = 1'b1;
    @(posedge clk); #1;
    chk("idle_rnd_ready", W'(rnd_ready), W'(1'b0));
    chk("idle_busy", W'(busy), W'(1'b0));
    rnd_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset aborts an encode after two transfers.
    data_in = d0;
    start   = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    rnd_valid = 1'b1;
    rnd_in    = CH'($urandom);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("mid_run_busy", W'(busy), W'(1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rnd_valid = 1'b0;
    chk("abort_busy", W'(busy), W'(1'b0));
    chk("abort_valid", W'(sharing_valid), W'(1'b0));
    chk("abort_rnd_ready", W'(rnd_ready), W'(1'b0));
    chk("abort_sharing", W'(sharing_out), W'(0));
    @(posedge clk); #1;
    chk("abort_stays_idle", W'(busy), W'(1'b0));
    run_vec(vecs[0]);

    for (int i = 0; i < 3; i++)
      run_d3({32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
